ref_bank_loader: RTL

Upstream fill stage for the reference-window Bank pair in the DMT motion-estimation datapath. Accepts a valid/ready stream of 8-pixel reference words from the external-memory fetch path and writes them, row by row, into one of two ping-pong Banks through their write port (`ref_in`, `write_address`, `Bank_sel`). It tracks which Bank holds a complete window, hands full Banks to the search engine, and stalls the stream until the engine releases a Bank.

---
 rtl/ref_bank_loader_if.sv | 21 ++
 rtl/ref_bank_loader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ref_bank_loader_if.sv
// Valid/ready stream carrying 8-pixel reference words from the external-memory
// fetch path into the Bank loader.
interface ref_bank_loader_if #(
    parameter int W = 64
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ref_bank_loader.sv
// Fills the ping-pong reference-window Banks row by row from a word stream,
// tracks which Banks hold complete windows and stalls until one is released.
module ref_bank_loader #(
    parameter int PIXEL    = 8,
    parameter int WORD_PIX = 8,
    parameter int DEPTH    = 96,
    parameter int AW       = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    ref_bank_loader_if.slave          up,
    input  logic                      flush,
    input  logic [1:0]                bank_release,
    output logic [PIXEL*WORD_PIX-1:0] ref_in,
    output logic [AW-1:0]             write_address,
    output logic                      wr_en,
    output logic                      Bank_sel,
    output logic [1:0]                bank_full,
    output logic                      bank_done,
    output logic                      done_sel
);

    localparam int DATA_W = PIXEL * WORD_PIX;
    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic            wsel, wsel_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [1:0]      full, full_nxt;
    logic            accept_p0;
    logic            last_row_p0;

    logic [DATA_W-1:0] data_p1;
    logic [AW-1:0]     addr_p1;
    logic              sel_p1;
    logic              vld_p1;
    logic              done_p1;
    logic              done_sel_p1;

    assign up.in_ready = (state == S_FILL);

    always_comb begin
        accept_p0   = up.in_valid & (state == S_FILL);
        last_row_p0 = accept_p0 && (cnt == LAST_ROW);

        // Releases are applied first so a completion can see the opposite
        // Bank freed in the same cycle; a set on the same Bank wins.
        full_nxt = full & ~bank_release;
        if (last_row_p0) begin
            full_nxt[wsel] = 1'b1;
        end

        wsel_nxt = wsel ^ last_row_p0;

        cnt_nxt = cnt;
        if (accept_p0) begin
            cnt_nxt = last_row_p0 ? '0 : cnt + AW'(1);
        end

        state_nxt = state;
        case (state)
            S_FILL: begin
                if (last_row_p0 && full_nxt[wsel_nxt]) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!full_nxt[wsel]) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Stage p0 -> p1: control state and the registered Bank write port
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= S_FILL;
            wsel        <= 1'b0;
            cnt         <= '0;
            full        <= 2'b00;
            vld_p1      <= 1'b0;
            data_p1     <= '0;
            addr_p1     <= '0;
            sel_p1      <= 1'b0;
            done_p1     <= 1'b0;
            done_sel_p1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            wsel    <= wsel_nxt;
            cnt     <= cnt_nxt;
            full    <= full_nxt;
            vld_p1  <= accept_p0;
            done_p1 <= last_row_p0;
            if (accept_p0) begin
                data_p1 <= up.in_data;
                addr_p1 <= cnt;
                sel_p1  <= wsel;
            end
            if (last_row_p0) begin
                done_sel_p1 <= wsel;
            end
        end
    end

    assign ref_in        = data_p1;
    assign write_address = addr_p1;
    assign Bank_sel      = sel_p1;
    assign wr_en         = vld_p1;
    assign bank_done     = done_p1;
    assign done_sel      = done_sel_p1;
    assign bank_full     = full;

endmodule
